// File: rtl/banco_registradores_pkg.sv
`default_nettype none
// ============================================================================
// Module      : banco_registradores_pkg
// Description : Shared constants and types for the general-purpose register
//               file. Reused by the decoder and the datapath so all three
//               agree on register width, address width and register count.
// Contents    : DATA_W, ADDR_W, NUM_REGS, REG_ZERO, word_t, addr_t
// Revision    : 1.0 - initial release
// ============================================================================
package banco_registradores_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;  // must equal 2**ADDR_W

    // Index of the hardwired-zero register.
    localparam int REG_ZERO = 0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage : banco_registradores_pkg
`default_nettype wire

// File: rtl/banco_registradores_if.sv
`default_nettype none
// ============================================================================
// Module      : banco_registradores_if
// Description : Bus between the control unit / decoder (master) and the
//               register file (slave): one write port, two read ports.
// Signals     : uc_escrita          write enable, active-high
//               dado_p_escrita      write data
//               endereco_escrita    write address
//               endereco_leitura_1  read port 1 address
//               endereco_leitura_2  read port 2 address
//               dado_leitura_1      read port 1 data (combinational)
//               dado_leitura_2      read port 2 data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
interface banco_registradores_if
    import banco_registradores_pkg::*;
#(
    parameter int DATA_W_P = banco_registradores_pkg::DATA_W,
    parameter int ADDR_W_P = banco_registradores_pkg::ADDR_W
) ();

    logic                uc_escrita;
    logic [DATA_W_P-1:0] dado_p_escrita;
    logic [ADDR_W_P-1:0] endereco_escrita;
    logic [ADDR_W_P-1:0] endereco_leitura_1;
    logic [ADDR_W_P-1:0] endereco_leitura_2;
    logic [DATA_W_P-1:0] dado_leitura_1;
    logic [DATA_W_P-1:0] dado_leitura_2;

    modport master (
        output uc_escrita,
        output dado_p_escrita,
        output endereco_escrita,
        output endereco_leitura_1,
        output endereco_leitura_2,
        input  dado_leitura_1,
        input  dado_leitura_2
    );

    modport slave (
        input  uc_escrita,
        input  dado_p_escrita,
        input  endereco_escrita,
        input  endereco_leitura_1,
        input  endereco_leitura_2,
        output dado_leitura_1,
        output dado_leitura_2
    );

endinterface : banco_registradores_if
`default_nettype wire

// File: rtl/banco_registradores_celula.sv
`default_nettype none
// ============================================================================
// Module      : banco_celula
// Description : One register of the register file. Asynchronous active-low
//               clear, loads d on the rising clock edge when en is high.
// Ports       : clk  clock
//               rst  asynchronous clear, active-low
//               en   write enable
//               d    data in
//               q    stored value
// Revision    : 1.0 - initial release
// ============================================================================
module banco_celula #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : banco_celula
`default_nettype wire

// File: rtl/banco_registradores.sv
`default_nettype none
// ============================================================================
// Module      : banco_registradores
// Description : 32 x 32-bit general-purpose register file. One synchronous
//               write port, two independent combinational read ports.
//               Register 0 is hardwired to zero; reads return the stored
//               value with no write-to-read bypass.
// Ports       : clk  clock, state changes on the rising edge
//               rst  asynchronous clear of all registers, active-low
//               bus  banco_registradores_if.slave (write + 2 read ports)
// Revision    : 1.0 - initial release
// ============================================================================
module banco_registradores #(
    parameter int DATA_W   = banco_registradores_pkg::DATA_W,
    parameter int ADDR_W   = banco_registradores_pkg::ADDR_W,
    parameter int NUM_REGS = banco_registradores_pkg::NUM_REGS
) (
    input  wire logic              clk,
    input  wire logic              rst,
    banco_registradores_if.slave   bus
);

    import banco_registradores_pkg::*;

    // Storage view indexed directly by address; entry REG_ZERO is tied low
    // so the read muxes need no special case for register 0.
    logic [DATA_W-1:0] w_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_we;

    assign w_regs[REG_ZERO] = '0;
    assign w_we[REG_ZERO]   = 1'b0;

    generate
        for (genvar i = 1; i < NUM_REGS; i++) begin : g_celula
            // One-hot write decode: a write to address 0 matches no cell.
            assign w_we[i] = bus.uc_escrita &&
                             (bus.endereco_escrita == ADDR_W'(i));

            banco_celula #(
                .WIDTH (DATA_W)
            ) u_celula (
                .clk (clk),
                .rst (rst),
                .en  (w_we[i]),
                .d   (bus.dado_p_escrita),
                .q   (w_regs[i])
            );
        end
    endgenerate

    // Read ports: plain muxes over stored values, so a read of the address
    // being written shows the old value until the edge.
    assign bus.dado_leitura_1 = w_regs[bus.endereco_leitura_1];
    assign bus.dado_leitura_2 = w_regs[bus.endereco_leitura_2];

endmodule : banco_registradores
`default_nettype wire

// File: tb/tb_banco_registradores.sv
`default_nettype none
// ============================================================================
// Module      : tb_banco_registradores
// Description : Self-checking bench for banco_registradores. Directed
//               scenarios plus a randomized run checked against an array
//               model of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banco_registradores;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;

    // Reference model: plain array of register contents.
    logic [31:0] model [32];

    banco_registradores_if bus ();

    banco_registradores u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    // Present a write for exactly one rising edge, then drop the enable.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        bus.uc_escrita       = 1'b1;
        bus.endereco_escrita = a;
        bus.dado_p_escrita   = d;
        @(posedge clk);
        #1;
        bus.uc_escrita = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    task automatic test_reset();
        bus.uc_escrita         = 1'b0;
        bus.dado_p_escrita     = 32'd0;
        bus.endereco_escrita   = 5'd0;
        bus.endereco_leitura_1 = 5'd1;
        bus.endereco_leitura_2 = 5'd31;
        rst = 1'b0;
        model_clear();
        // A write attempted while reset is held must be ignored.
        bus.uc_escrita       = 1'b1;
        bus.endereco_escrita = 5'd1;
        bus.dado_p_escrita   = 32'h1234_5678;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.dado_leitura_1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_hold_write: got %h expected %h", bus.dado_leitura_1, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.uc_escrita = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.dado_leitura_1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_r1: got %h expected %h", bus.dado_leitura_1, 32'd0);
        end
        tests_run++;
        if (bus.dado_leitura_2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_r31: got %h expected %h", bus.dado_leitura_2, 32'd0);
        end
    endtask

    task automatic test_basic_write();
        do_write(5'd2, 32'd10);
        bus.endereco_leitura_1 = 5'd2;
        bus.endereco_leitura_2 = 5'd0;
        #1;
        tests_run++;
        if (bus.dado_leitura_1 !== 32'd10) begin
            tests_failed++;
            $display("FAIL basic_r2: got %h expected %h", bus.dado_leitura_1, 32'd10);
        end
        tests_run++;
        if (bus.dado_leitura_2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL basic_r0: got %h expected %h", bus.dado_leitura_2, 32'd0);
        end
    endtask

    task automatic test_write_disabled();
        bus.uc_escrita       = 1'b0;
        bus.dado_p_escrita   = 32'hDEAD_BEEF;
        bus.endereco_escrita = 5'd2;
        repeat (3) @(posedge clk);
        #1;
        bus.endereco_leitura_1 = 5'd2;
        #1;
        tests_run++;
        if (bus.dado_leitura_1 !== 32'd10) begin
            tests_failed++;
            $display("FAIL write_disabled: got %h expected %h", bus.dado_leitura_1, 32'd10);
        end
    endtask

    task automatic test_reg_zero();
        do_write(5'd0, 32'hFFFF_FFFF);
        bus.endereco_leitura_1 = 5'd0;
        bus.endereco_leitura_2 = 5'd0;
        #1;
        tests_run++;
        if (bus.dado_leitura_1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reg0_port1: got %h expected %h", bus.dado_leitura_1, 32'd0);
        end
        tests_run++;
        if (bus.dado_leitura_2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reg0_port2: got %h expected %h", bus.dado_leitura_2, 32'd0);
        end
    endtask

    task automatic test_dual_port();
        do_write(5'd7, 32'd5);
        do_write(5'd31, 32'd9);
        bus.endereco_leitura_1 = 5'd7;
        bus.endereco_leitura_2 = 5'd31;
        #1;
        tests_run++;
        if (bus.dado_leitura_1 !== 32'd5) begin
            tests_failed++;
            $display("FAIL dual_r7: got %h expected %h", bus.dado_leitura_1, 32'd5);
        end
        tests_run++;
        if (bus.dado_leitura_2 !== 32'd9) begin
            tests_failed++;
            $display("FAIL dual_r31: got %h expected %h", bus.dado_leitura_2, 32'd9);
        end
    endtask

    task automatic test_read_during_write();
        bus.endereco_leitura_1 = 5'd7;
        bus.endereco_leitura_2 = 5'd7;
        bus.uc_escrita         = 1'b1;
        bus.endereco_escrita   = 5'd7;
        bus.dado_p_escrita     = 32'd6;
        #1;
        tests_run++;
        if (bus.dado_leitura_1 !== 32'd5) begin
            tests_failed++;
            $display("FAIL rdw_before: got %h expected %h", bus.dado_leitura_1, 32'd5);
        end
        @(posedge clk);
        #1;
        bus.uc_escrita = 1'b0;
        model[7] = 32'd6;
        tests_run++;
        if (bus.dado_leitura_1 !== 32'd6) begin
            tests_failed++;
            $display("FAIL rdw_after_p1: got %h expected %h", bus.dado_leitura_1, 32'd6);
        end
        tests_run++;
        if (bus.dado_leitura_2 !== 32'd6) begin
            tests_failed++;
            $display("FAIL rdw_after_p2: got %h expected %h", bus.dado_leitura_2, 32'd6);
        end
    endtask

    task automatic test_random();
        logic [4:0]  wa, ra1, ra2;
        logic [31:0] wd;
        logic        we;
        for (int n = 0; n < 300; n++) begin
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            ra1 = 5'($urandom_range(0, 31));
            // Bias port 2 toward the write address to exercise read-during-write.
            ra2 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
            bus.uc_escrita         = we;
            bus.endereco_escrita   = wa;
            bus.dado_p_escrita     = wd;
            bus.endereco_leitura_1 = ra1;
            bus.endereco_leitura_2 = ra2;
            #1;
            tests_run++;
            if (bus.dado_leitura_1 !== model_read(ra1)) begin
                tests_failed++;
                $display("FAIL rand_p1 it=%0d addr=%0d: got %h expected %h",
                         n, ra1, bus.dado_leitura_1, model_read(ra1));
            end
            tests_run++;
            if (bus.dado_leitura_2 !== model_read(ra2)) begin
                tests_failed++;
                $display("FAIL rand_p2 it=%0d addr=%0d: got %h expected %h",
                         n, ra2, bus.dado_leitura_2, model_read(ra2));
            end
            @(posedge clk);
            if (we && wa != 5'd0) model[wa] = wd;
            #1;
        end
        bus.uc_escrita = 1'b0;
    endtask

    task automatic test_async_reset();
        do_write(5'd2, 32'd10);
        do_write(5'd7, 32'd6);
        bus.endereco_leitura_1 = 5'd2;
        bus.endereco_leitura_2 = 5'd7;
        #1;
        tests_run++;
        if (bus.dado_leitura_1 !== 32'd10 || bus.dado_leitura_2 !== 32'd6) begin
            tests_failed++;
            $display("FAIL async_preload: got %h/%h expected %h/%h",
                     bus.dado_leitura_1, bus.dado_leitura_2, 32'd10, 32'd6);
        end
        // Pulse reset between edges (posedge at ..5, next at ..15).
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.dado_leitura_1 !== 32'd0 || bus.dado_leitura_2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL async_clear_no_edge: got %h/%h expected 0/0",
                     bus.dado_leitura_1, bus.dado_leitura_2);
        end
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        for (int a = 0; a < 32; a += 2) begin
            bus.endereco_leitura_1 = 5'(a);
            bus.endereco_leitura_2 = 5'(a + 1);
            #1;
            tests_run++;
            if (bus.dado_leitura_1 !== model_read(5'(a)) ||
                bus.dado_leitura_2 !== model_read(5'(a + 1))) begin
                tests_failed++;
                $display("FAIL async_all_zero addr=%0d/%0d: got %h/%h expected 0/0",
                         a, a + 1, bus.dado_leitura_1, bus.dado_leitura_2);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic_write();
        test_write_disabled();
        test_reg_zero();
        test_dual_port();
        test_read_during_write();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_banco_registradores
`default_nettype wire

// File: doc/banco_registradores.md
Name: banco_registradores

Overview:
- General-purpose register file for the team's 32-bit processor datapath: 32 registers of 32 bits, one synchronous write port, two combinational read ports.
- Sits between the instruction decoder/control unit (supplies addresses and the `uc_escrita` write enable) and the ALU/writeback path.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, width of the register address ports.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- uc_escrita  input  1  write enable from the control unit; active-high.
- dado_p_escrita  input  DATA_W  data to write.
- endereco_escrita  input  ADDR_W  destination register address.
- endereco_leitura_1  input  ADDR_W  read port 1 address.
- endereco_leitura_2  input  ADDR_W  read port 2 address.
- dado_leitura_1  output  DATA_W  contents of register endereco_leitura_1.
- dado_leitura_2  output  DATA_W  contents of register endereco_leitura_2.

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low; the ports are named `clk` and `rst`.
- Reset:
  - `rst`=0 immediately clears all NUM_REGS registers to 0, independent of `clk`.
  - While `rst`=0, both read outputs show 0 and writes are ignored.
  - Reset asserted mid-write wins: the register ends at 0.
- Write:
  - On a rising `clk` edge with `rst`=1 and `uc_escrita`=1, register[`endereco_escrita`] <= `dado_p_escrita`.
  - With `uc_escrita`=0, no register changes.
  - Latency: the new value is visible on the read ports immediately after that edge.
- Register 0:
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0.
- Read:
  - Purely combinational, 0-cycle latency. `dado_leitura_N` = register[`endereco_leitura_N`], or 0 when the address is 0.
  - Both ports are fully independent; the same address on both ports returns the same value.
- Read-during-write (read address equals write address, `uc_escrita`=1, before the edge):
  - The read returns the old stored value; there is no bypass.
  - The new value appears after the edge.
- Unknown/X addresses are a caller error; no defined output is required.
- All addresses are in range by construction (ADDR_W bits, NUM_REGS = 2**ADDR_W); there is no wrap or overflow case.
- No other state, no handshake, no stall.

Decomposition:
- Shared package (e.g. `banco_pkg`) holds DATA_W, ADDR_W, NUM_REGS, the register-0 index constant (0) and a `word_t` typedef of DATA_W bits, for reuse by decoder and datapath.
- One natural sub-module: `banco_celula`, a single DATA_W register with async active-low clear and write enable. It is instantiated NUM_REGS-1 times via generate; index 0 is a constant zero.
- Read muxes and write-address decode stay in the top module.

Test Plan:
- Reset: drive `rst`=0 for 2 cycles, then `rst`=1; read addresses 1 and 31 -> `dado_leitura_1`=0, `dado_leitura_2`=0.
- Basic write/read: write 10 to address 2 with `uc_escrita`=1 for one edge, then `uc_escrita`=0; set `endereco_leitura_1`=2, `endereco_leitura_2`=0 -> `dado_leitura_1`=10, `dado_leitura_2`=0.
- Write disabled: `uc_escrita`=0, `dado_p_escrita`=0xDEADBEEF, `endereco_escrita`=2, clock 3 edges -> reading address 2 still returns 10.
- Register 0 hardwired: write 0xFFFFFFFF to address 0 -> both ports reading address 0 return 0.
- Dual-port and read-during-write:
  - Write 5 to r7 and 9 to r31; read 7 and 31 simultaneously -> 5 and 9.
  - With r7=5, present a write of 6 to r7 and read r7 before the edge -> 5; after the edge -> 6.
- Async reset mid-operation: after loading r2=10 and r7=6, pulse `rst`=0 between clock edges -> both outputs drop to 0 without waiting for a clock edge, and all registers read 0 afterwards.
